// File: rtl/serial_pattern_gen.sv
// Serial pattern generator: shifts a captured pattern out MSB first and counts
// the two-consecutive-ones hits a downstream detector is expected to report.
module serial_pattern_gen #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [3:0]       len,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic [3:0]       exp_count
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [3:0] WIDTH_L = 4'(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [3:0]       bitsLeft_q, bitsLeft_d;
    logic             prevBit_q, prevBit_d;
    logic [3:0]       expCount_q, expCount_d;
    logic             x_q, x_d;
    logic             xValid_q, xValid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [3:0]       capLen;

    assign capLen = (len > WIDTH_L) ? WIDTH_L : len;

    // State and every registered output; reset wins over any pending start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bitsLeft_q <= '0;
            prevBit_q  <= 1'b0;
            expCount_q <= '0;
            x_q        <= 1'b0;
            xValid_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bitsLeft_q <= bitsLeft_d;
            prevBit_q  <= prevBit_d;
            expCount_q <= expCount_d;
            x_q        <= x_d;
            xValid_q   <= xValid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (capLen == 4'd0) ? DONE : SHIFT;
            SHIFT:   if (bitsLeft_q == 4'd0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // bitsLeft counts the bits still waiting behind the one currently on x.
    always_comb begin
        shift_d    = shift_q;
        bitsLeft_d = bitsLeft_q;
        prevBit_d  = prevBit_q;
        expCount_d = expCount_q;
        x_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d    = {pattern[WIDTH-2:0], 1'b0};
                    bitsLeft_d = capLen - 4'd1;
                    prevBit_d  = 1'b0;
                    expCount_d = '0;
                    x_d        = pattern[WIDTH-1] & (capLen != 4'd0);
                end
            end
            SHIFT: begin
                if (x_q && prevBit_q) expCount_d = expCount_q + 4'd1;
                prevBit_d = x_q;
                if (bitsLeft_q != 4'd0) begin
                    x_d        = shift_q[WIDTH-1];
                    shift_d    = {shift_q[WIDTH-2:0], 1'b0};
                    bitsLeft_d = bitsLeft_q - 4'd1;
                end
            end
            default: ;
        endcase
        xValid_d = (state_d == SHIFT);
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
    end

    assign x         = x_q;
    assign x_valid   = xValid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign exp_count = expCount_q;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Self-checking bench for serial_pattern_gen: directed frame table, reset
// corner cases, and random frames checked against a bit-list reference model.
module tb_serial_pattern_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] pattern = '0;
    logic [3:0] len = '0;
    logic       x, x_valid, busy, done;
    logic [3:0] exp_count;

    int checkCount = 0;
    int passCount = 0;

    typedef struct {
        logic [7:0]  pattern;
        logic [3:0]  len;
        bit          hold;
        logic [15:0] expBits;
        int          nBits;
        int          expCount;
    } vec_t;

    vec_t vecs[5];

    serial_pattern_gen #(.WIDTH(8)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .pattern(pattern),
        .len(len),
        .x(x),
        .x_valid(x_valid),
        .busy(busy),
        .done(done),
        .exp_count(exp_count)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic s, input logic [7:0] pat, input logic [3:0] ln);
        start   = s;
        pattern = pat;
        len     = ln;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Adjacent 1-1 pairs among the first n bits of a left-aligned bit list.
    function automatic int pairsUpTo(input logic [15:0] bits, input int n);
        int p = 0;
        for (int i = 1; i < n; i++)
            if (bits[15-i] && bits[16-i]) p++;
        return p;
    endfunction

    // Caller must be at a negedge with the DUT in IDLE; this cycle is cycle 0.
    task automatic runFrame(input logic [7:0] pat, input logic [3:0] ln, input bit hold,
                            input logic [15:0] eb, input int nb, input int ec, input string tag);
        applyStimulus(1'b1, pat, ln);
        for (int c = 1; c <= nb + 2; c++) begin
            @(negedge clk);
            if (!hold || c == nb + 2) start = 1'b0;
            if (c <= nb) begin
                checkOutput($sformatf("%s c%0d x_valid", tag, c), x_valid, 1);
                checkOutput($sformatf("%s c%0d x", tag, c), x, eb[16-c]);
                checkOutput($sformatf("%s c%0d busy", tag, c), busy, 1);
                checkOutput($sformatf("%s c%0d done", tag, c), done, 0);
                checkOutput($sformatf("%s c%0d exp_count", tag, c), exp_count, pairsUpTo(eb, c - 1));
            end else if (c == nb + 1) begin
                checkOutput($sformatf("%s c%0d done", tag, c), done, 1);
                checkOutput($sformatf("%s c%0d x_valid", tag, c), x_valid, 0);
                checkOutput($sformatf("%s c%0d x", tag, c), x, 0);
                checkOutput($sformatf("%s c%0d busy", tag, c), busy, 1);
                checkOutput($sformatf("%s c%0d exp_count", tag, c), exp_count, ec);
            end else begin
                checkOutput($sformatf("%s c%0d idle busy", tag, c), busy, 0);
                checkOutput($sformatf("%s c%0d idle done", tag, c), done, 0);
                checkOutput($sformatf("%s c%0d idle x_valid", tag, c), x_valid, 0);
                checkOutput($sformatf("%s c%0d held exp_count", tag, c), exp_count, ec);
            end
        end
        if (hold) begin
            @(negedge clk);
            checkOutput($sformatf("%s no restart from DONE", tag), busy, 0);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " x"}, x, 0);
        checkOutput({tag, " x_valid"}, x_valid, 0);
        checkOutput({tag, " busy"}, busy, 0);
        checkOutput({tag, " done"}, done, 0);
        checkOutput({tag, " exp_count"}, exp_count, 0);
    endtask

    initial begin
        logic [7:0]  rPat;
        logic [3:0]  rLen;
        logic [15:0] rBits;
        int          rN;
        bit          rHold;

        vecs[0] = '{8'b1101_1100, 4'd8,  1'b0, 16'b1101_1100_0000_0000, 8, 3};
        vecs[1] = '{8'b1110_0000, 4'd3,  1'b0, 16'b1110_0000_0000_0000, 3, 2};
        vecs[2] = '{8'h5A,        4'd0,  1'b0, 16'h0000,                0, 0};
        vecs[3] = '{8'hFF,        4'd12, 1'b0, 16'b1111_1111_0000_0000, 8, 7};
        vecs[4] = '{8'hAA,        4'd8,  1'b1, 16'b1010_1010_0000_0000, 8, 0};

        applyStimulus(1'b1, 8'hFF, 4'd8);
        repeat (3) @(negedge clk);
        checkAllZero("reset state");
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checkAllZero("idle after reset");

        for (int i = 0; i < 5; i++)
            runFrame(vecs[i].pattern, vecs[i].len, vecs[i].hold, vecs[i].expBits,
                     vecs[i].nBits, vecs[i].expCount, $sformatf("vec%0d", i));

        // Reset in cycle 4 of a full-length frame aborts it silently.
        applyStimulus(1'b1, 8'b1101_1100, 4'd8);
        @(negedge clk);
        start = 1'b0;
        checkOutput("abort c1 x", x, 1);
        repeat (3) @(negedge clk);
        checkOutput("abort c4 x_valid", x_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkAllZero("abort c5");
        for (int c = 6; c <= 12; c++) begin
            @(negedge clk);
            checkOutput($sformatf("abort c%0d done", c), done, 0);
            checkOutput($sformatf("abort c%0d busy", c), busy, 0);
        end
        runFrame(8'b1101_1100, 4'd8, 1'b0, 16'b1101_1100_0000_0000, 8, 3, "post-abort");

        // Reset and start together: reset wins, nothing starts.
        reset = 1'b1;
        applyStimulus(1'b1, 8'hFF, 4'd8);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        checkAllZero("reset+start c1");
        @(negedge clk);
        checkAllZero("reset+start c2");

        for (int f = 0; f < 40; f++) begin
            rPat  = 8'($urandom);
            rLen  = 4'($urandom_range(0, 15));
            rHold = bit'($urandom_range(0, 1));
            rN    = (int'(rLen) < 8) ? int'(rLen) : 8;
            rBits = '0;
            for (int i = 0; i < rN; i++) rBits[15-i] = rPat[7-i];
            runFrame(rPat, rLen, rHold, rBits, rN, pairsUpTo(rBits, rN), $sformatf("rand%0d", f));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
